assert_seq_window: RTL and testbench
====================================

Name: assert_seq_window

Overview:
- Clocked output checker that sits directly downstream of a DUT/reference-model pair in the frontend test benches. It consumes the model's expected value and the DUT's actual output.
- Aligns the expected value to the DUT's pipeline latency, ignores a settle window after enable, and counts mismatches.
- Captures the first failure for reporting.
- Synthesizable, so it can also be read through the frontends under test.

Parameters:
- WIDTH, 1, bit width of compared values
- LATENCY, 1, cycles expected value is delayed before compare (0..8; 0 = same-cycle compare)
- SETTLE, 2, compare-free cycles after entering check mode (0..255)
- CNT_W, 8, width of err_count and cmp_count
- MASK, all ones (WIDTH bits), bits participating in compare
- STOP_ON_FAIL, 0, 1 = freeze all counters/captures after the first mismatch until clr

Ports:
- clk  in  1  sampling clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  check enable; expected sample valid while high
- clr  in  1  synchronous clear of state, counters, captures
- exp_in  in  WIDTH  expected value from reference model
- act_in  in  WIDTH  DUT output
- mismatch  out  1  one-cycle registered pulse per mismatching compare
- fail  out  1  sticky; set on first mismatch
- err_count  out  CNT_W  saturating mismatch count
- cmp_count  out  CNT_W  saturating count of compares performed
- first_idx  out  CNT_W  cmp_count value at first mismatch
- first_exp  out  WIDTH  aligned expected value at first mismatch
- first_act  out  WIDTH  act_in at first mismatch
- checking  out  1  high while FSM in CHECK

Behaviour:
- Reset (rst_n=0, async): state IDLE. All outputs and the delay line, including its valid bits, are 0.
- Delay line: {en, exp_in} shifted LATENCY stages. exp_d/vld_d are the stage outputs. With LATENCY=0, exp_d=exp_in and vld_d=en.
- FSM states:
  - IDLE: go to SETTLE when en=1. When SETTLE=0, go straight to CHECK.
  - SETTLE: count SETTLE cycles with en=1, then go to CHECK.
  - CHECK: compare each cycle while en=1.
  - HALT: entered only when STOP_ON_FAIL=1, in the cycle of the first mismatch.
  - en=0 in SETTLE or CHECK: go to IDLE and flush the valid bits. Counters and captures are kept.
  - HALT is left only by clr or reset.
- Compare condition: state==CHECK && en && vld_d. Mismatch = ((exp_d ^ act_in) & MASK) != 0.
- Outputs on compare are registered, with 1-cycle latency:
  - cmp_count+1, saturating at all-ones.
  - On mismatch: err_count+1 (saturating), mismatch=1 for one cycle, fail=1.
  - If fail was 0, capture first_idx=cmp_count (pre-increment), first_exp=exp_d, first_act=act_in.
- Saturation: counters hold at 2^CNT_W-1. mismatch still pulses.
- clr: takes priority over en and over a compare in the same cycle. Next cycle: state IDLE, all outputs 0, delay line flushed.
- en deasserting in the same cycle as a valid compare: that compare is not performed, because en is sampled.
- checking = (state==CHECK), registered.

Decomposition:
- Package assert_seq_pkg:
  - state enum {IDLE, SETTLE, CHECK, HALT}
  - LATENCY_MAX=8 and SETTLE_MAX=255 constants
- Sub-module assert_seq_delay: LATENCY-deep shift register carrying {valid, data}. Async active-low reset, synchronous flush input.
- Top holds the FSM, compare logic, counters and capture.

Test Plan:
- WIDTH=1, LATENCY=1, SETTLE=2; en=1 from cycle 0; act_in = exp_in delayed 1 → compares begin at cycle 3, and cmp_count=10 after 10 compares. err_count=0, fail=0.
- Same config; flip act_in at the 5th compare → mismatch pulses once, fail=1, err_count=1, first_idx=4. first_exp/first_act hold the differing values.
- CNT_W=2; force a mismatch on every compare for 6 compares → err_count saturates at 3, mismatch pulses 6 times, first_idx=0.
- STOP_ON_FAIL=1; mismatch at compare 2, then 5 more mismatches → err_count=1, cmp_count=3, state HALT. clr → all outputs 0, and re-enable resumes checking.
- Drop en for one cycle mid-CHECK → checking falls, valids flush, and SETTLE reruns (2 cycles). No compare occurs on stale expected data.
- Assert rst_n=0 asynchronously mid-CHECK with fail=1 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/assert_seq_window_pkg.sv
// rtl/assert_seq_window_pkg.sv - shared types and limits for the sequence-window checker
package assert_seq_pkg;

  // Prefixed names keep the states clear of the SETTLE parameter in the top module
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam int LATENCY_MAX  = 8;
  localparam int SETTLE_MAX   = 255;
  localparam int SETTLE_CNT_W = 8;

endpackage

// File: rtl/assert_seq_window_if.sv
// rtl/assert_seq_window_if.sv - stimulus/result bundle between a bench driver and the checker
interface assert_seq_window_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] exp_in;
  logic [WIDTH-1:0] act_in;
  logic             mismatch;
  logic             fail;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] cmp_count;
  logic [CNT_W-1:0] first_idx;
  logic [WIDTH-1:0] first_exp;
  logic [WIDTH-1:0] first_act;
  logic             checking;

  modport master (
    output en, clr, exp_in, act_in,
    input  mismatch, fail, err_count, cmp_count, first_idx, first_exp, first_act, checking
  );

  modport slave (
    input  en, clr, exp_in, act_in,
    output mismatch, fail, err_count, cmp_count, first_idx, first_exp, first_act, checking
  );
endinterface

// File: rtl/assert_seq_window_delay.sv
// rtl/assert_seq_window_delay.sv - LATENCY-deep {valid, data} alignment shift register
module assert_seq_delay #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (LATENCY == 0) begin : g_pass
      logic w_unused;
      assign w_unused = ^{clk, rst_n, i_flush};
      assign o_vld    = i_vld;
      assign o_data   = i_data;
    end else begin : g_pipe
      logic             r_vld  [LATENCY];
      logic [WIDTH-1:0] r_data [LATENCY];

      // Shift stages each cycle; a flush empties every stage so no stale sample survives
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) begin
            r_vld[i]  <= 1'b0;
            r_data[i] <= '0;
          end
        end else if (i_flush) begin
          for (int i = 0; i < LATENCY; i++) begin
            r_vld[i]  <= 1'b0;
            r_data[i] <= '0;
          end
        end else begin
          r_vld[0]  <= i_vld;
          r_data[0] <= i_data;
          for (int i = 1; i < LATENCY; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_data[i] <= r_data[i-1];
          end
        end
      end

      assign o_vld  = r_vld[LATENCY-1];
      assign o_data = r_data[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/assert_seq_window.sv
// rtl/assert_seq_window.sv - latency-aligned output checker with settle window and first-fail capture
module assert_seq_window #(
  parameter int               WIDTH        = 1,
  parameter int               LATENCY      = 1,
  parameter int               SETTLE       = 2,
  parameter int               CNT_W        = 8,
  parameter logic [WIDTH-1:0] MASK         = '1,
  parameter bit               STOP_ON_FAIL = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  assert_seq_window_if.slave bus
);
  import assert_seq_pkg::*;

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
    (SETTLE == 0) ? '0 : SETTLE_CNT_W'(SETTLE - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SETTLE_CNT_W-1:0] r_settle_cnt;
  logic [SETTLE_CNT_W-1:0] w_settle_nxt;

  logic             w_vld_d;
  logic [WIDTH-1:0] w_exp_d;
  logic             w_flush;
  logic             w_cmp;
  logic             w_miss;

  logic             r_mismatch;
  logic             r_fail;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_cmp_count;
  logic [CNT_W-1:0] r_first_idx;
  logic [WIDTH-1:0] r_first_exp;
  logic [WIDTH-1:0] r_first_act;

  // Leaving the active window (or clearing) must drop every in-flight expected sample
  assign w_flush = bus.clr |
                   (((r_state == ST_SETTLE) || (r_state == ST_CHECK)) && !bus.en);

  assert_seq_delay #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_vld   (bus.en),
    .i_data  (bus.exp_in),
    .o_vld   (w_vld_d),
    .o_data  (w_exp_d)
  );

  // en is part of the compare condition, so a sample arriving as en falls is dropped
  assign w_cmp  = (r_state == ST_CHECK) && bus.en && w_vld_d && !bus.clr;
  assign w_miss = w_cmp && (((w_exp_d ^ bus.act_in) & MASK) != '0);

  // Next-state logic: clr wins, en low aborts the window, HALT only exits via clr
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    if (bus.clr) begin
      w_state_nxt  = ST_IDLE;
      w_settle_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.en) begin
            w_state_nxt  = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
            w_settle_nxt = '0;
          end
        end
        ST_SETTLE: begin
          if (!bus.en) begin
            w_state_nxt = ST_IDLE;
          end else if (r_settle_cnt == SETTLE_LAST) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_settle_nxt = r_settle_cnt + SETTLE_CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (!bus.en) begin
            w_state_nxt = ST_IDLE;
          end else if (STOP_ON_FAIL && w_miss) begin
            w_state_nxt = ST_HALT;
          end
        end
        default: begin
          w_state_nxt = ST_HALT;
        end
      endcase
    end
  end

  // State and settle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  // Result registers: saturating counters, mismatch pulse, first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch  <= 1'b0;
      r_fail      <= 1'b0;
      r_err_count <= '0;
      r_cmp_count <= '0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_act <= '0;
    end else if (bus.clr) begin
      r_mismatch  <= 1'b0;
      r_fail      <= 1'b0;
      r_err_count <= '0;
      r_cmp_count <= '0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_act <= '0;
    end else begin
      r_mismatch <= w_miss;
      if (w_cmp) begin
        if (r_cmp_count != '1) begin
          r_cmp_count <= r_cmp_count + CNT_W'(1);
        end
        if (w_miss) begin
          if (r_err_count != '1) begin
            r_err_count <= r_err_count + CNT_W'(1);
          end
          r_fail <= 1'b1;
          if (!r_fail) begin
            r_first_idx <= r_cmp_count;
            r_first_exp <= w_exp_d;
            r_first_act <= bus.act_in;
          end
        end
      end
    end
  end

  assign bus.mismatch  = r_mismatch;
  assign bus.fail      = r_fail;
  assign bus.err_count = r_err_count;
  assign bus.cmp_count = r_cmp_count;
  assign bus.first_idx = r_first_idx;
  assign bus.first_exp = r_first_exp;
  assign bus.first_act = r_first_act;
  assign bus.checking  = (r_state == ST_CHECK);

endmodule

// File: tb/tb_assert_seq_window.sv
// tb/tb_assert_seq_window.sv - directed self-checking bench for assert_seq_window
module tb_assert_seq_window;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] pat = 16'hB2D5;

  always #5 clk = ~clk;

  assert_seq_window_if #(.WIDTH(1), .CNT_W(8)) ifa ();
  assert_seq_window_if #(.WIDTH(1), .CNT_W(2)) ifb ();
  assert_seq_window_if #(.WIDTH(1), .CNT_W(8)) ifc ();
  assert_seq_window_if #(.WIDTH(4), .CNT_W(8)) ifd ();

  assert_seq_window #(.WIDTH(1), .LATENCY(1), .SETTLE(2), .CNT_W(8), .MASK(1'b1), .STOP_ON_FAIL(1'b0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  assert_seq_window #(.WIDTH(1), .LATENCY(1), .SETTLE(2), .CNT_W(2), .MASK(1'b1), .STOP_ON_FAIL(1'b0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  assert_seq_window #(.WIDTH(1), .LATENCY(1), .SETTLE(2), .CNT_W(8), .MASK(1'b1), .STOP_ON_FAIL(1'b1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
  assert_seq_window #(.WIDTH(4), .LATENCY(0), .SETTLE(0), .CNT_W(8), .MASK(4'b0111), .STOP_ON_FAIL(1'b0))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ifa.en = 0; ifa.clr = 0; ifa.exp_in = 0; ifa.act_in = 0;
    ifb.en = 0; ifb.clr = 0; ifb.exp_in = 0; ifb.act_in = 0;
    ifc.en = 0; ifc.clr = 0; ifc.exp_in = 0; ifc.act_in = 0;
    ifd.en = 0; ifd.clr = 0; ifd.exp_in = 0; ifd.act_in = 0;
    tick;
    tick;
    checks++; if (ifa.checking !== 1'b0) begin failures++; $display("FAIL reset_checking got=%0b exp=0", ifa.checking); end
    checks++; if (ifa.cmp_count !== 8'd0) begin failures++; $display("FAIL reset_cmp_count got=%0d exp=0", ifa.cmp_count); end
    checks++; if (ifa.fail !== 1'b0) begin failures++; $display("FAIL reset_fail got=%0b exp=0", ifa.fail); end
    checks++; if (ifa.mismatch !== 1'b0) begin failures++; $display("FAIL reset_mismatch got=%0b exp=0", ifa.mismatch); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    for (int c = 0; c < 13; c++) begin
      ifa.en = 1'b1;
      ifa.exp_in = pat[c];
      ifa.act_in = (c == 0) ? 1'b0 : pat[c-1];
      tick;
      if (c == 2) begin
        checks++; if (ifa.checking !== 1'b1) begin failures++; $display("FAIL basic_checking_c2 got=%0b exp=1", ifa.checking); end
        checks++; if (ifa.cmp_count !== 8'd0) begin failures++; $display("FAIL basic_cmp_c2 got=%0d exp=0", ifa.cmp_count); end
      end
      if (c == 3) begin
        checks++; if (ifa.cmp_count !== 8'd1) begin failures++; $display("FAIL basic_cmp_c3 got=%0d exp=1", ifa.cmp_count); end
      end
    end
    checks++; if (ifa.cmp_count !== 8'd10) begin failures++; $display("FAIL basic_cmp_count got=%0d exp=10", ifa.cmp_count); end
    checks++; if (ifa.err_count !== 8'd0) begin failures++; $display("FAIL basic_err_count got=%0d exp=0", ifa.err_count); end
    checks++; if (ifa.fail !== 1'b0) begin failures++; $display("FAIL basic_fail got=%0b exp=0", ifa.fail); end
  endtask

  task automatic test_en_drop;
    ifa.en = 1'b0; ifa.exp_in = 1'b1; ifa.act_in = 1'b0;
    tick;
    checks++; if (ifa.checking !== 1'b0) begin failures++; $display("FAIL drop_checking got=%0b exp=0", ifa.checking); end
    checks++; if (ifa.cmp_count !== 8'd10) begin failures++; $display("FAIL drop_cmp got=%0d exp=10", ifa.cmp_count); end
    for (int c = 0; c < 3; c++) begin
      ifa.en = 1'b1; ifa.exp_in = 1'b1; ifa.act_in = 1'b0;
      tick;
      if (c == 1) begin
        checks++; if (ifa.checking !== 1'b0) begin failures++; $display("FAIL drop_settle_checking got=%0b exp=0", ifa.checking); end
      end
    end
    checks++; if (ifa.checking !== 1'b1) begin failures++; $display("FAIL drop_recheck got=%0b exp=1", ifa.checking); end
    checks++; if (ifa.cmp_count !== 8'd10) begin failures++; $display("FAIL drop_no_stale_cmp got=%0d exp=10", ifa.cmp_count); end
    ifa.exp_in = 1'b0; ifa.act_in = 1'b1;
    tick;
    checks++; if (ifa.cmp_count !== 8'd11) begin failures++; $display("FAIL drop_resume_cmp got=%0d exp=11", ifa.cmp_count); end
    checks++; if (ifa.err_count !== 8'd0) begin failures++; $display("FAIL drop_err got=%0d exp=0", ifa.err_count); end
  endtask

  task automatic test_first_fail;
    logic e6;
    e6 = pat[6];
    ifa.clr = 1'b1; ifa.en = 1'b1;
    tick;
    ifa.clr = 1'b0;
    checks++; if (ifa.cmp_count !== 8'd0) begin failures++; $display("FAIL clr_cmp got=%0d exp=0", ifa.cmp_count); end
    checks++; if (ifa.checking !== 1'b0) begin failures++; $display("FAIL clr_checking got=%0b exp=0", ifa.checking); end
    for (int c = 0; c < 10; c++) begin
      ifa.en = 1'b1;
      ifa.exp_in = pat[c];
      ifa.act_in = (c == 0) ? 1'b0 : ((c == 7) ? ~pat[c-1] : pat[c-1]);
      tick;
      if (c == 7) begin
        checks++; if (ifa.mismatch !== 1'b1) begin failures++; $display("FAIL ff_mismatch got=%0b exp=1", ifa.mismatch); end
        checks++; if (ifa.fail !== 1'b1) begin failures++; $display("FAIL ff_fail got=%0b exp=1", ifa.fail); end
        checks++; if (ifa.err_count !== 8'd1) begin failures++; $display("FAIL ff_err got=%0d exp=1", ifa.err_count); end
        checks++; if (ifa.first_idx !== 8'd4) begin failures++; $display("FAIL ff_first_idx got=%0d exp=4", ifa.first_idx); end
        checks++; if (ifa.first_exp !== e6) begin failures++; $display("FAIL ff_first_exp got=%0b exp=%0b", ifa.first_exp, e6); end
        checks++; if (ifa.first_act !== ~e6) begin failures++; $display("FAIL ff_first_act got=%0b exp=%0b", ifa.first_act, ~e6); end
      end
      if (c == 8) begin
        checks++; if (ifa.mismatch !== 1'b0) begin failures++; $display("FAIL ff_pulse_end got=%0b exp=0", ifa.mismatch); end
        checks++; if (ifa.fail !== 1'b1) begin failures++; $display("FAIL ff_sticky got=%0b exp=1", ifa.fail); end
      end
    end
  endtask

  task automatic test_saturate;
    int pulses;
    pulses = 0;
    for (int c = 0; c < 9; c++) begin
      ifb.en = 1'b1;
      ifb.exp_in = pat[c];
      ifb.act_in = (c == 0) ? 1'b1 : ~pat[c-1];
      tick;
      if (ifb.mismatch === 1'b1) pulses++;
    end
    checks++; if (ifb.err_count !== 2'd3) begin failures++; $display("FAIL sat_err got=%0d exp=3", ifb.err_count); end
    checks++; if (ifb.cmp_count !== 2'd3) begin failures++; $display("FAIL sat_cmp got=%0d exp=3", ifb.cmp_count); end
    checks++; if (pulses !== 6) begin failures++; $display("FAIL sat_pulses got=%0d exp=6", pulses); end
    checks++; if (ifb.first_idx !== 2'd0) begin failures++; $display("FAIL sat_first_idx got=%0d exp=0", ifb.first_idx); end
    checks++; if (ifb.mismatch !== 1'b1) begin failures++; $display("FAIL sat_last_pulse got=%0b exp=1", ifb.mismatch); end
    ifb.en = 1'b0;
  endtask

  task automatic test_stop_on_fail;
    for (int c = 0; c < 11; c++) begin
      ifc.en = 1'b1;
      ifc.exp_in = pat[c];
      ifc.act_in = (c == 0) ? 1'b0 : ((c >= 5) ? ~pat[c-1] : pat[c-1]);
      tick;
      if (c == 5) begin
        checks++; if (ifc.checking !== 1'b0) begin failures++; $display("FAIL sof_halt_checking got=%0b exp=0", ifc.checking); end
        checks++; if (ifc.cmp_count !== 8'd3) begin failures++; $display("FAIL sof_cmp_c5 got=%0d exp=3", ifc.cmp_count); end
        checks++; if (ifc.first_idx !== 8'd2) begin failures++; $display("FAIL sof_first_idx got=%0d exp=2", ifc.first_idx); end
        checks++; if (ifc.mismatch !== 1'b1) begin failures++; $display("FAIL sof_mismatch got=%0b exp=1", ifc.mismatch); end
      end
    end
    checks++; if (ifc.err_count !== 8'd1) begin failures++; $display("FAIL sof_err_frozen got=%0d exp=1", ifc.err_count); end
    checks++; if (ifc.cmp_count !== 8'd3) begin failures++; $display("FAIL sof_cmp_frozen got=%0d exp=3", ifc.cmp_count); end
    checks++; if (ifc.mismatch !== 1'b0) begin failures++; $display("FAIL sof_no_pulse got=%0b exp=0", ifc.mismatch); end
    checks++; if (ifc.fail !== 1'b1) begin failures++; $display("FAIL sof_fail got=%0b exp=1", ifc.fail); end
    ifc.clr = 1'b1;
    tick;
    ifc.clr = 1'b0;
    checks++; if (ifc.fail !== 1'b0) begin failures++; $display("FAIL sof_clr_fail got=%0b exp=0", ifc.fail); end
    checks++; if (ifc.err_count !== 8'd0) begin failures++; $display("FAIL sof_clr_err got=%0d exp=0", ifc.err_count); end
    checks++; if (ifc.first_idx !== 8'd0) begin failures++; $display("FAIL sof_clr_idx got=%0d exp=0", ifc.first_idx); end
    for (int c = 0; c < 5; c++) begin
      ifc.en = 1'b1;
      ifc.exp_in = pat[c];
      ifc.act_in = (c == 0) ? 1'b0 : pat[c-1];
      tick;
    end
    checks++; if (ifc.cmp_count !== 8'd2) begin failures++; $display("FAIL sof_resume_cmp got=%0d exp=2", ifc.cmp_count); end
    checks++; if (ifc.checking !== 1'b1) begin failures++; $display("FAIL sof_resume_checking got=%0b exp=1", ifc.checking); end
    ifc.en = 1'b0;
  endtask

  task automatic test_mask_lat0;
    ifd.en = 1'b1; ifd.exp_in = 4'h5; ifd.act_in = 4'h0;
    tick;
    checks++; if (ifd.checking !== 1'b1) begin failures++; $display("FAIL m0_checking got=%0b exp=1", ifd.checking); end
    checks++; if (ifd.cmp_count !== 8'd0) begin failures++; $display("FAIL m0_cmp_idle got=%0d exp=0", ifd.cmp_count); end
    ifd.exp_in = 4'hA; ifd.act_in = 4'h2;
    tick;
    checks++; if (ifd.mismatch !== 1'b0) begin failures++; $display("FAIL m0_masked_bit got=%0b exp=0", ifd.mismatch); end
    ifd.exp_in = 4'h3; ifd.act_in = 4'h1;
    tick;
    checks++; if (ifd.err_count !== 8'd1) begin failures++; $display("FAIL m0_err got=%0d exp=1", ifd.err_count); end
    checks++; if (ifd.first_idx !== 8'd1) begin failures++; $display("FAIL m0_first_idx got=%0d exp=1", ifd.first_idx); end
    checks++; if (ifd.first_exp !== 4'h3) begin failures++; $display("FAIL m0_first_exp got=%0h exp=3", ifd.first_exp); end
    checks++; if (ifd.first_act !== 4'h1) begin failures++; $display("FAIL m0_first_act got=%0h exp=1", ifd.first_act); end
    ifd.exp_in = 4'hF; ifd.act_in = 4'h7;
    tick;
    checks++; if (ifd.cmp_count !== 8'd3) begin failures++; $display("FAIL m0_cmp got=%0d exp=3", ifd.cmp_count); end
    checks++; if (ifd.err_count !== 8'd1) begin failures++; $display("FAIL m0_err_hold got=%0d exp=1", ifd.err_count); end
    ifd.en = 1'b0;
  endtask

  task automatic test_async_reset;
    checks++; if (ifa.fail !== 1'b1) begin failures++; $display("FAIL ar_pre_fail got=%0b exp=1", ifa.fail); end
    checks++; if (ifa.checking !== 1'b1) begin failures++; $display("FAIL ar_pre_checking got=%0b exp=1", ifa.checking); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ifa.fail !== 1'b0) begin failures++; $display("FAIL ar_fail got=%0b exp=0", ifa.fail); end
    checks++; if (ifa.checking !== 1'b0) begin failures++; $display("FAIL ar_checking got=%0b exp=0", ifa.checking); end
    checks++; if (ifa.err_count !== 8'd0) begin failures++; $display("FAIL ar_err got=%0d exp=0", ifa.err_count); end
    checks++; if (ifa.cmp_count !== 8'd0) begin failures++; $display("FAIL ar_cmp got=%0d exp=0", ifa.cmp_count); end
    checks++; if (ifa.first_idx !== 8'd0) begin failures++; $display("FAIL ar_first_idx got=%0d exp=0", ifa.first_idx); end
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_en_drop;
    test_first_fail;
    test_saturate;
    test_stop_on_fail;
    test_mask_lat0;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
